// File: rtl/fp_sqrt_sched.sv
// Shares one pipelined fp_sqrt among num_req requesters: round-robin issue, tag tracking
// through the fixed datapath latency, and a one-entry response buffer per requester.
module fp_sqrt_sched #(
    parameter int unsigned sig_width   = 23,
    parameter int unsigned ex_width    = 8,
    parameter int unsigned pipe_stages = 0,
    parameter int unsigned num_req     = 4,
    localparam int unsigned W          = sig_width + ex_width + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [num_req-1:0]   req_valid,
    output logic [num_req-1:0]   req_ready,
    input  logic [num_req*W-1:0] req_a,
    input  logic [num_req*3-1:0] req_round,
    output logic [num_req-1:0]   resp_valid,
    input  logic [num_req-1:0]   resp_ready,
    output logic [num_req*W-1:0] resp_z,
    output logic [num_req*8-1:0] resp_status,
    output logic [W-1:0]         sq_a,
    output logic [2:0]           sq_round,
    output logic                 sq_enable,
    output logic                 sq_resetn,
    input  logic [W-1:0]         sq_z,
    input  logic [7:0]           sq_status,
    output logic                 busy
);

    localparam int unsigned L   = pipe_stages;
    localparam int unsigned IDW = (num_req > 1) ? $clog2(num_req) : 1;

    logic [IDW-1:0]     ptr;
    logic [num_req-1:0] inflight;
    logic [num_req-1:0] elig;
    logic               grant;
    logic [IDW-1:0]     gid;
    logic [W-1:0]       a_arr   [num_req];
    logic [2:0]         rnd_arr [num_req];
    logic [W-1:0]       last_a;
    logic [2:0]         last_round;
    logic               exit_v;
    logic [IDW-1:0]     exit_id;
    int unsigned        idx;

    // Eligibility uses registered state only; nothing is granted while in reset.
    assign elig = req_valid & ~inflight & ~resp_valid & {num_req{~reset}};

    // Round-robin search starting at ptr.
    always_comb begin
        grant = 1'b0;
        gid   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < num_req; i++) begin
            idx = (32'(ptr) + i) % num_req;
            if (!grant && elig[IDW'(idx)]) begin
                grant = 1'b1;
                gid   = IDW'(idx);
            end
        end
    end

    assign sq_a      = grant ? a_arr[gid] : last_a;
    assign sq_round  = grant ? rnd_arr[gid] : last_round;
    assign sq_enable = ~reset;
    assign sq_resetn = ~reset;
    assign busy      = (|inflight) | (|resp_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            last_a     <= '0;
            last_round <= '0;
        end else if (grant) begin
            ptr        <= (gid == IDW'(num_req - 1)) ? '0 : gid + IDW'(1);
            last_a     <= a_arr[gid];
            last_round <= rnd_arr[gid];
        end
    end

    // Tag tracking: {valid, id} travels alongside the operand through the datapath.
    if (L == 0) begin : g_comb_tag
        assign exit_v  = grant;
        assign exit_id = gid;
    end else begin : g_pipe_tag
        logic [L-1:0]          tag_v;
        logic [L-1:0][IDW-1:0] tag_id;

        always_ff @(posedge clk) begin
            if (reset) begin
                tag_v  <= '0;
                tag_id <= '0;
            end else begin
                tag_v  <= L'({tag_v, grant});
                tag_id <= (L*IDW)'({tag_id, gid});
            end
        end

        assign exit_v  = tag_v[L-1];
        assign exit_id = tag_id[L-1];
    end

    for (genvar i = 0; i < num_req; i++) begin : g_req
        localparam logic [IDW-1:0] ID = IDW'(i);
        logic         hit_grant;
        logic         hit_exit;
        logic         rv;
        logic         inf;
        logic [W-1:0] z;
        logic [7:0]   st;

        assign a_arr[i]   = req_a[i*W +: W];
        assign rnd_arr[i] = req_round[i*3 +: 3];
        assign hit_grant  = grant && (gid == ID);
        assign hit_exit   = exit_v && (exit_id == ID);

        // A capture never meets a full buffer, so capture and release cannot collide.
        always_ff @(posedge clk) begin
            if (reset) begin
                rv  <= 1'b0;
                inf <= 1'b0;
                z   <= '0;
                st  <= '0;
            end else begin
                if (hit_grant) inf <= 1'b1;
                if (hit_exit)  inf <= 1'b0;
                if (rv && resp_ready[i]) rv <= 1'b0;
                if (hit_exit) begin
                    rv <= 1'b1;
                    z  <= sq_z;
                    st <= sq_status;
                end
            end
        end

        assign req_ready[i]         = hit_grant;
        assign inflight[i]          = inf;
        assign resp_valid[i]        = rv;
        assign resp_z[i*W +: W]     = z;
        assign resp_status[i*8 +: 8] = st;
    end

endmodule
